scan_index_sequencer: RTL and testbench

Generates the 3-bit index that drives the 3-to-8 one-hot decoder stage directly downstream, for LED chaser and display-scan use. Steps the index through 0..7 under programmable dwell time and direction mode. Provides start/stop control, an index preload, and step/done pulses so downstream logic can sample each new index.

---
 rtl/scan_index_sequencer_pkg.sv | 65 ++++++
 rtl/scan_index_sequencer_if.sv | 28 ++
 rtl/scan_index_sequencer_dwell_timer.sv | 35 +++
 rtl/scan_index_sequencer.sv | 104 ++++++++++
 tb/tb_scan_index_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/scan_index_sequencer_pkg.sv
// Shared encodings and the index-advance rule for the scan index sequencer.
// The advance function is pure so the top level only decides when to apply it.
package scan_index_sequencer_pkg;

    localparam logic [2:0] IDX_MAX = 3'd7;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_SINGLE   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [2:0] idx;
        dir_e       dir;
        logic       done;
    } advance_t;

    // done marks the end of a single sweep: the index stays put instead of wrapping.
    function automatic advance_t next_index(input logic [2:0] idx, input mode_e mode,
                                            input dir_e dir);
        advance_t res;
        res = '{idx: idx, dir: dir, done: 1'b0};
        case (mode)
            MODE_UP:   res.idx = idx + 3'd1;
            MODE_DOWN: res.idx = idx - 3'd1;
            MODE_PINGPONG: begin
                if (dir == DIR_UP) begin
                    if (idx == IDX_MAX) begin
                        res.idx = IDX_MAX - 3'd1;
                        res.dir = DIR_DOWN;
                    end else begin
                        res.idx = idx + 3'd1;
                    end
                end else begin
                    if (idx == 3'd0) begin
                        res.idx = 3'd1;
                        res.dir = DIR_UP;
                    end else begin
                        res.idx = idx - 3'd1;
                    end
                end
            end
            MODE_SINGLE: begin
                if (idx == IDX_MAX) res.done = 1'b1;
                else                res.idx  = idx + 3'd1;
            end
            default: res.idx = idx;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scan_index_sequencer_if.sv
// Control inputs and index/status outputs of the scan index sequencer.
interface scan_index_sequencer_if #(
    parameter int DWELL_W = 8
) ();
    import scan_index_sequencer_pkg::*;

    logic               start;
    logic               stop;
    mode_e              mode;
    logic [DWELL_W-1:0] dwell;
    logic               load;
    logic [2:0]         load_idx;
    logic [2:0]         idx;
    logic               busy;
    logic               step;
    logic               done;

    modport master (
        output start, stop, mode, dwell, load, load_idx,
        input  idx, busy, step, done
    );

    modport slave (
        input  start, stop, mode, dwell, load, load_idx,
        output idx, busy, step, done
    );

endinterface

// File: rtl/scan_index_sequencer_dwell_timer.sv
// Dwell counter: counts while running and flags the cycle whose edge should advance the index.
// The count is retained while not running so a paused dwell resumes exactly where it stopped.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               clear_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               tc_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Exact equality: a dwell lowered below the count wraps through 2^DWELL_W.
    assign tc_o = run_i && (cnt_q == dwell_i);

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/scan_index_sequencer.sv
// Steps a 3-bit decoder index through 0..7 with programmable dwell and direction mode.
// All outputs are registered; state, index and pulses update on the same edge.
module scan_index_sequencer
    import scan_index_sequencer_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int IDX_W   = 3
) (
    input logic                    clk,
    input logic                    rst,
    scan_index_sequencer_if.slave  bus_if
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    dir_e             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;
    logic             done_q, done_d;

    logic     tc;
    logic     timer_run;
    logic     timer_clear;
    logic     go;
    logic     sweep_done;
    advance_t adv;

    assign go          = bus_if.start && !bus_if.stop;
    assign timer_run   = (state_q == RUN);
    assign timer_clear = bus_if.load || (state_q == IDLE && go);

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .run_i   (timer_run),
        .clear_i (timer_clear),
        .dwell_i (bus_if.dwell),
        .tc_o    (tc)
    );

    assign adv        = next_index(idx_q, bus_if.mode, dir_q);
    assign sweep_done = tc && !bus_if.load && adv.done;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (go) state_d = RUN;
            RUN: begin
                if (sweep_done)       state_d = IDLE;
                else if (bus_if.stop) state_d = HOLD;
            end
            HOLD: if (go) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // A load always beats a pending advance: no step and no done in that cycle.
    always_comb begin
        idx_d  = idx_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == RUN);
        if (bus_if.load) begin
            idx_d = bus_if.load_idx;
            dir_d = DIR_UP;
        end else if (tc) begin
            if (adv.done) begin
                done_d = 1'b1;
            end else begin
                idx_d  = adv.idx;
                dir_d  = adv.dir;
                step_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            dir_q  <= DIR_UP;
            busy_q <= 1'b0;
            step_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            busy_q <= busy_d;
            step_q <= step_d;
            done_q <= done_d;
        end
    end

    assign bus_if.idx  = idx_q;
    assign bus_if.busy = busy_q;
    assign bus_if.step = step_q;
    assign bus_if.done = done_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Directed bench for scan_index_sequencer: inputs change and outputs are checked on the falling edge.
module tb_scan_index_sequencer;
    import scan_index_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    scan_index_sequencer_if #(.DWELL_W(8)) sif ();

    scan_index_sequencer #(.DWELL_W(8), .IDX_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (sif)
    );

    task automatic chk(input string tag, input int e_idx, input bit e_busy,
                       input bit e_step, input bit e_done);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {sif.idx, sif.busy, sif.step, sif.done};
        exp = {3'(e_idx), e_busy, e_step, e_done};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed idx=%0d busy=%b step=%b done=%b expected idx=%0d busy=%b step=%b done=%b",
                   tag, obs[5:3], obs[2], obs[1], obs[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        int pp[16];
        int dn[7];
        pp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        dn = '{5, 4, 3, 2, 1, 0, 7};

        rst          = 1'b1;
        sif.start    = 1'b0;
        sif.stop     = 1'b0;
        sif.mode     = MODE_UP;
        sif.dwell    = 8'd0;
        sif.load     = 1'b0;
        sif.load_idx = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Up-wrap, dwell 0: one step per cycle.
        sif.start = 1'b1;
        @(negedge clk);
        chk("up_start", 0, 1, 0, 0);
        sif.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("up_step", i % 8, 1, 1, 0);
        end

        // Ping-pong, dwell 2, restarted from 0 by a load while running.
        sif.load     = 1'b1;
        sif.load_idx = 3'd0;
        sif.mode     = MODE_PINGPONG;
        sif.dwell    = 8'd2;
        @(negedge clk);
        chk("pp_load", 0, 1, 0, 0);
        sif.load = 1'b0;
        for (int k = 1; k < 16; k++) begin
            repeat (2) begin
                @(negedge clk);
                chk("pp_hold", pp[k-1], 1, 0, 0);
            end
            @(negedge clk);
            chk("pp_step", pp[k], 1, 1, 0);
        end

        // Single sweep from 5, dwell 1.
        sif.mode     = MODE_SINGLE;
        sif.dwell    = 8'd1;
        sif.load     = 1'b1;
        sif.load_idx = 3'd5;
        sif.start    = 1'b1;
        @(negedge clk);
        chk("single_load", 5, 1, 0, 0);
        sif.load  = 1'b0;
        sif.start = 1'b0;
        @(negedge clk); chk("single_5", 5, 1, 0, 0);
        @(negedge clk); chk("single_6s", 6, 1, 1, 0);
        @(negedge clk); chk("single_6", 6, 1, 0, 0);
        @(negedge clk); chk("single_7s", 7, 1, 1, 0);
        @(negedge clk); chk("single_7", 7, 1, 0, 0);
        @(negedge clk); chk("single_done", 7, 0, 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("single_after", 7, 0, 0, 0);
        end

        // Down-wrap, dwell 3, paused mid-dwell by stop for 10 cycles.
        sif.mode  = MODE_DOWN;
        sif.dwell = 8'd3;
        sif.start = 1'b1;
        @(negedge clk);
        chk("down_start", 7, 1, 0, 0);
        sif.start = 1'b0;
        @(negedge clk);
        chk("down_cnt1", 7, 1, 0, 0);
        sif.stop = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("down_hold", 7, 0, 0, 0);
        end
        sif.stop  = 1'b0;
        sif.start = 1'b1;
        @(negedge clk);
        chk("down_resume", 7, 1, 0, 0);
        sif.start = 1'b0;
        @(negedge clk);
        chk("down_cnt3", 7, 1, 0, 0);
        @(negedge clk);
        chk("down_step6", 6, 1, 1, 0);
        for (int k = 0; k < 7; k++) begin
            repeat (3) @(negedge clk);
            @(negedge clk);
            chk("down_wrap", dn[k], 1, 1, 0);
        end

        // Mode switch up -> ping-pong at idx 7 with dir up.
        sif.load     = 1'b1;
        sif.load_idx = 3'd7;
        sif.mode     = MODE_UP;
        sif.dwell    = 8'd1;
        @(negedge clk);
        chk("sw_load", 7, 1, 0, 0);
        sif.load = 1'b0;
        sif.mode = MODE_PINGPONG;
        @(negedge clk); chk("sw_hold7", 7, 1, 0, 0);
        @(negedge clk); chk("sw_step6", 6, 1, 1, 0);
        @(negedge clk); chk("sw_hold6", 6, 1, 0, 0);
        @(negedge clk); chk("sw_step5", 5, 1, 1, 0);
        @(negedge clk);
        @(negedge clk); chk("sw_step4", 4, 1, 1, 0);

        // Reset while running at idx 4, with start also high.
        rst       = 1'b1;
        sif.start = 1'b1;
        @(negedge clk);
        chk("rst_run", 0, 0, 0, 0);

        // start and stop together from IDLE: stop wins.
        rst      = 1'b0;
        sif.stop = 1'b1;
        @(negedge clk); chk("startstop_1", 0, 0, 0, 0);
        @(negedge clk); chk("startstop_2", 0, 0, 0, 0);
        sif.stop  = 1'b0;
        sif.mode  = MODE_UP;
        sif.dwell = 8'd0;
        @(negedge clk);
        chk("restart", 0, 1, 0, 0);
        sif.start = 1'b0;
        @(negedge clk);
        chk("restart_step", 1, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
